// File: rtl/pipelined_barrel_rotator.sv
// Pipelined rotate/shift unit: log2(W) registered stages, stage k applies a 2^k step; latency L.
// One global stall (out_valid & ~out_ready) freezes every stage and drops in_ready.
module pipelined_barrel_rotator #(
    parameter  int DATA_WIDTH  = 256,
    localparam int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             mode_in,
    input  logic [DATA_WIDTH-1:0]  a_in,
    input  logic [SHIFT_WIDTH-1:0] shift_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  a_out,
    output logic                   err_out
);
    localparam int L = SHIFT_WIDTH;

    typedef enum logic [1:0] {
        OP_ROT = 2'd0,
        OP_SHL = 2'd1,
        OP_SHR = 2'd2,
        OP_SRA = 2'd3
    } op_t;

    logic                   w_stall;
    logic [DATA_WIDTH-1:0]  w_in_dat;
    logic [SHIFT_WIDTH-1:0] w_in_amt;
    op_t                    w_in_op;
    logic                   w_in_err;

    logic [DATA_WIDTH-1:0]  r_dat [L];
    logic [SHIFT_WIDTH-1:0] r_amt [L];
    op_t                    r_op  [L];
    logic [L-1:0]           r_vld;
    logic [L-1:0]           r_err;

    logic [DATA_WIDTH-1:0]  w_src_dat [L];
    logic [SHIFT_WIDTH-1:0] w_src_amt [L];
    op_t                    w_src_op  [L];
    logic [DATA_WIDTH-1:0]  w_nxt_dat [L];
    logic [L-1:0]           w_src_vld;
    logic [L-1:0]           w_src_err;

    function automatic logic [DATA_WIDTH-1:0] step_fn(input logic [DATA_WIDTH-1:0] d,
                                                      input op_t op, input logic en,
                                                      input int k);
        int sh;
        sh      = 1 << k;
        step_fn = d;
        if (en) begin
            case (op)
                OP_ROT:  step_fn = (d << sh) | (d >> (DATA_WIDTH - sh));
                OP_SHL:  step_fn = d << sh;
                OP_SHR:  step_fn = d >> sh;
                default: step_fn = $unsigned($signed(d) >>> sh);
            endcase
        end
    endfunction

    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    // ROTR becomes ROTL by the negated amount; reserved modes flow as zero data with err set.
    // Bubbles carry zero data so nothing undefined can reach a_out.
    always_comb begin
        w_in_dat = in_valid ? a_in : '0;
        w_in_amt = shift_in;
        w_in_op  = OP_ROT;
        w_in_err = 1'b0;
        case (mode_in)
            3'b000:  w_in_op = OP_ROT;
            3'b001:  w_in_amt = -shift_in;
            3'b010:  w_in_op = OP_SHL;
            3'b011:  w_in_op = OP_SHR;
            3'b100:  w_in_op = OP_SRA;
            default: begin
                w_in_dat = '0;
                w_in_err = in_valid;
            end
        endcase
    end

    always_comb begin
        w_src_dat[0] = w_in_dat;
        w_src_amt[0] = w_in_amt;
        w_src_op[0]  = w_in_op;
        for (int k = 1; k < L; k++) begin
            w_src_dat[k] = r_dat[k-1];
            w_src_amt[k] = r_amt[k-1];
            w_src_op[k]  = r_op[k-1];
        end
        for (int k = 0; k < L; k++) begin
            w_nxt_dat[k] = step_fn(w_src_dat[k], w_src_op[k], w_src_amt[k][k], k);
        end
    end

    assign w_src_vld = {r_vld[L-2:0], in_valid};
    assign w_src_err = {r_err[L-2:0], w_in_err};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld <= '0;
            r_err <= '0;
            for (int k = 0; k < L; k++) begin
                r_dat[k] <= '0;
                r_amt[k] <= '0;
                r_op[k]  <= OP_ROT;
            end
        end else if (!w_stall) begin
            r_vld <= w_src_vld;
            r_err <= w_src_err;
            for (int k = 0; k < L; k++) begin
                r_dat[k] <= w_nxt_dat[k];
                r_amt[k] <= w_src_amt[k];
                r_op[k]  <= w_src_op[k];
            end
        end
    end

    assign out_valid = r_vld[L-1];
    assign a_out     = r_dat[L-1];
    assign err_out   = r_err[L-1];

endmodule

// File: tb/tb_pipelined_barrel_rotator.sv
// Scoreboard bench: directed cases on an 8-bit unit, random traffic on a 256-bit unit.
module tb_pipelined_barrel_rotator;
    logic         clk = 1'b0;
    logic         rst;
    logic         sel;
    logic         in_valid;
    logic [2:0]   mode;
    logic [255:0] a;
    logic [7:0]   s;
    logic         out_ready;

    logic         in_rdy8, ov8, eo8;
    logic [7:0]   ao8;
    logic         in_rdy256, ov256, eo256;
    logic [255:0] ao256;

    logic         in_rdy, ov, eo;
    logic [255:0] ao;

    typedef struct {
        logic [255:0] dat;
        logic         err;
        int           cyc;
        int           stl;
    } exp_t;

    exp_t         sb [$];
    exp_t         e;
    int           n_chk = 0;
    int           n_pass = 0;
    int           cyc = 0;
    int           stall_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [255:0] prev_dat = '0;
    logic         rnd_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    pipelined_barrel_rotator #(.DATA_WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(in_rdy8),
        .mode_in(mode), .a_in(a[7:0]), .shift_in(s[2:0]),
        .out_valid(ov8), .out_ready(out_ready), .a_out(ao8), .err_out(eo8)
    );

    pipelined_barrel_rotator #(.DATA_WIDTH(256)) u_dut256 (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(in_rdy256),
        .mode_in(mode), .a_in(a), .shift_in(s),
        .out_valid(ov256), .out_ready(out_ready), .a_out(ao256), .err_out(eo256)
    );

    assign in_rdy = sel ? in_rdy256 : in_rdy8;
    assign ov     = sel ? ov256 : ov8;
    assign eo     = sel ? eo256 : eo8;
    assign ao     = sel ? ao256 : {248'b0, ao8};

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [255:0] model(input logic [255:0] av, input logic [2:0] m,
                                           input int sv, input int w);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < w; i++) begin
            case (m)
                3'd0:    r[i] = av[(i - sv + w) % w];
                3'd1:    r[i] = av[(i + sv) % w];
                3'd2:    r[i] = (i >= sv) ? av[i - sv] : 1'b0;
                3'd3:    r[i] = (i + sv < w) ? av[i + sv] : 1'b0;
                3'd4:    r[i] = (i + sv < w) ? av[i + sv] : av[w-1];
                default: r[i] = 1'b0;
            endcase
        end
        return r;
    endfunction

    // Called just after a rising edge; returns just after the edge that took the op.
    task automatic send(input logic [2:0] m, input logic [255:0] av, input logic [7:0] sv,
                        input logic [255:0] ed, input logic ee);
        int n;
        n = 0;
        in_valid = 1'b1;
        mode     = m;
        a        = av;
        s        = sv;
        @(negedge clk);
        while (!in_rdy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) begin
            check("send_timeout", 0, 1);
        end else begin
            sb.push_back('{dat: ed, err: ee, cyc: cyc, stl: stall_cnt});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: pops on handshake, checks hold behaviour and in_ready during stalls.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (ov && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("data", ao, e.dat);
                    check("err", eo, e.err);
                    check("latency", cyc, e.cyc + (sel ? 8 : 3) + (stall_cnt - e.stl));
                end
            end
            if (prev_stall) begin
                check("hold_vld", ov, 1);
                check("hold_dat", ao, prev_dat);
            end
            if (ov && !out_ready) begin
                check("in_ready_stall", in_rdy, 0);
                stall_cnt++;
            end
            if (sel ? ov8 : ov256) check("idle_unit_quiet", 1, 0);
            prev_stall = ov && !out_ready;
            prev_dat   = ao;
        end
    end

    initial begin
        logic [2:0]   rm;
        logic [255:0] ra;
        logic [7:0]   rs;
        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; mode = '0; a = '0; s = '0; out_ready = 1'b1;
        rnd_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", ov8, 0);
        check("rst_a_out", ao8, 0);
        check("rst_err_out", eo8, 0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", in_rdy8, 1);

        // single op right after reset release
        send(3'b000, 256'h81, 8'd1, 256'h03, 1'b0);
        drain();

        // back-to-back mixed modes
        send(3'b001, 256'h01, 8'd1, 256'h80, 1'b0);
        send(3'b011, 256'h80, 8'd7, 256'h01, 1'b0);
        send(3'b100, 256'h80, 8'd7, 256'hFF, 1'b0);
        send(3'b010, 256'hFF, 8'd4, 256'hF0, 1'b0);
        send(3'b100, 256'h80, 8'd0, 256'h80, 1'b0);
        send(3'b001, 256'h81, 8'd7, 256'h03, 1'b0);
        send(3'b011, 256'hFF, 8'd0, 256'hFF, 1'b0);
        send(3'b010, 256'h81, 8'd7, 256'h80, 1'b0);
        send(3'b101, 256'hFF, 8'd3, 256'h00, 1'b1);
        drain();

        // reserved mode then zero rotate
        send(3'b111, 256'hA5, 8'd2, 256'h00, 1'b1);
        send(3'b000, 256'hA5, 8'd0, 256'hA5, 1'b0);
        drain();

        // back-pressure across a 4-cycle stall window
        fork
            begin
                send(3'b000, 256'h12, 8'd4, 256'h21, 1'b0);
                send(3'b010, 256'h01, 8'd7, 256'h80, 1'b0);
                send(3'b011, 256'hF0, 8'd4, 256'h0F, 1'b0);
                send(3'b100, 256'h40, 8'd1, 256'h20, 1'b0);
                send(3'b001, 256'h0F, 8'd2, 256'hC3, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // asynchronous reset with two ops in flight
        send(3'b000, 256'h11, 8'd1, 256'h22, 1'b0);
        send(3'b000, 256'h33, 8'd1, 256'h66, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", ov8, 0);
        check("async_rst_a_out", ao8, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send(3'b010, 256'h03, 8'd2, 256'h0C, 1'b0);
        drain();

        // random traffic on the wide unit
        sel = 1'b1;
        @(posedge clk);
        #1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(0, 9) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    rm = 3'($urandom_range(0, 7));
                    ra = {$urandom(), $urandom(), $urandom(), $urandom(),
                          $urandom(), $urandom(), $urandom(), $urandom()};
                    rs = 8'($urandom_range(0, 255));
                    send(rm, ra, rs, model(ra, rm, int'(rs), 256), rm > 3'd4);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
